countdown_bcd_timer: RTL
========================

COUNTDOWN_BCD_TIMER -- requirements
Module: countdown_bcd_timer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: number of BCD digits in the count, legal range 1..6.
REQ-002 SHALL have parameter START_BCD, default 'h30 (30): reset/reload count, 4*NUM_DIGITS bits, BCD-encoded.
REQ-003 SHALL have parameter WARN_BCD, default 'h05 (5): threshold for the warning flag, BCD-encoded.
REQ-004 SHALL have clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have tick, input, 1: one-clk-wide pulse, once per second.
REQ-007 SHALL have start, input, 1: level, sampled each clk; begins or resumes counting.
REQ-008 SHALL have pause, input, 1: level, sampled each clk; halts counting.
REQ-009 SHALL have load, input, 1: level, sampled each clk; loads load_value.
REQ-010 SHALL have load_value, input, 4*NUM_DIGITS: new BCD count.
REQ-011 SHALL have count_bcd, output, 4*NUM_DIGITS: current remaining count, registered.
REQ-012 SHALL have running, output, 1: high in state RUN.
REQ-013 SHALL have warn, output, 1: high when running and count_bcd <= WARN_BCD.
REQ-014 SHALL have game_finished, output, 1: high in state DONE.
REQ-015 SHALL have hex, output, 7*NUM_DIGITS: active-low 7-segment patterns; digit i at bits [7i+6:7i], digit 0 = ones.

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-017 IDLE: load -> IDLE with new count; start -> RUN. RUN: pause -> PAUSED; tick -> decrement. PAUSED: start -> RUN; load -> PAUSED with new count. DONE: load -> IDLE with new count; start -> no effect.
REQ-018 Same-cycle priority SHALL be load > pause > start; load in RUN SHALL be ignored.
REQ-019 tick SHALL decrement count_bcd only in RUN, in the cycle tick is sampled high, with no pause in that cycle; tick in all other states SHALL be ignored.
REQ-020 Decrement SHALL be per-digit BCD with borrow: a 0 digit becomes 9 and borrows from the next digit (e.g. 30 -> 29, 10 -> 09, 100 -> 099).
REQ-021 When a decrement yields zero, count_bcd SHALL become 0 and the state SHALL become DONE on the same clock edge; game_finished SHALL rise in that cycle.
REQ-022 start in IDLE or PAUSED with count_bcd = 0 SHALL go directly to DONE on the next edge.
REQ-023 Loaded digits > 9 SHALL be clamped to 9 digit by digit.
REQ-024 count_bcd SHALL never wrap below zero.
REQ-025 hex SHALL be combinational from count_bcd: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; non-BCD = 1111111.

Reset
REQ-026 rst high SHALL immediately force IDLE, count_bcd = START_BCD, running = 0, warn = 0, game_finished = 0, blink phase = 0, independent of clk.
REQ-027 rst asserted mid-count SHALL discard progress; counting SHALL require a fresh start after release.

Configuration
REQ-028 Macro COUNTDOWN_BLINK_EN SHALL, when defined, add a blink phase register that toggles on each accepted tick while warn is high, and drive all hex digits to 1111111 while the phase is 1; in DONE, hex SHALL show the 0 pattern steadily.
REQ-029 Without COUNTDOWN_BLINK_EN, the phase register SHALL be absent and hex SHALL always follow REQ-025.

Verification
REQ-030 Reset, start, 30 ticks -> count_bcd 30, 29 ... 01, 00; game_finished = 1 on the 30th tick's edge; running = 0.
REQ-031 NUM_DIGITS=3, load 'h100, start, 1 tick -> count_bcd = 'h099, hex[20:14] = 1000000.
REQ-032 Start, 3 ticks (27), pause, 5 ticks, start, 1 tick -> count stays 27 during pause, then 26.
REQ-033 Load 'h0F in IDLE -> count_bcd = 'h09; load during RUN -> count unchanged.
REQ-034 Load 0 then start -> DONE next edge, game_finished = 1; rst asserted at count 12 -> immediate 30, IDLE.
REQ-035 With COUNTDOWN_BLINK_EN, count 06 -> 05 on a tick -> warn = 1, hex all 1111111; next tick -> 04 displayed.

Source files
------------

// File: rtl/countdown_bcd_timer.sv
// countdown_bcd_timer
// BCD countdown timer with IDLE / RUN / PAUSED / DONE control and active-low
// 7-segment patterns for every digit (digit 0 = ones, in hex[6:0]).
// NUM_DIGITS is intended to be in the range 1..6.
// Optional feature: define COUNTDOWN_BLINK_EN to blank the display on
// alternate ticks while the warning window is active. DONE then shows
// steady zeros.
module countdown_bcd_timer #(
  parameter int                      NUM_DIGITS = 2,
  parameter logic [4*NUM_DIGITS-1:0] START_BCD  = 'h30,
  parameter logic [4*NUM_DIGITS-1:0] WARN_BCD   = 'h05
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  output logic [4*NUM_DIGITS-1:0]   count_bcd,
  output logic                      running,
  output logic                      warn,
  output logic                      game_finished,
  output logic [7*NUM_DIGITS-1:0]   hex
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_nextCount;
  logic [W-1:0]   w_clampCount;
  logic [W-1:0]   w_decCount;
  logic           w_countZero;
  logic           w_decZero;
  logic           w_tickAccept;
  logic           w_loadAccept;

  // Active-low 7-segment pattern for one BCD digit; non-BCD codes go blank.
  function automatic logic [6:0] f_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  // Clamp each incoming load digit to 9 so the count is always valid BCD.
  always_comb begin
    w_clampCount = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) begin
        w_clampCount[4*i +: 4] = 4'd9;
      end else begin
        w_clampCount[4*i +: 4] = load_value[4*i +: 4];
      end
    end
  end

  // Per-digit BCD decrement: a zero digit becomes 9 and passes the borrow up.
  always_comb begin
    logic v_borrow;
    v_borrow   = 1'b1;
    w_decCount = r_count;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_decCount[4*i +: 4] = 4'd9;
        end else begin
          w_decCount[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          v_borrow             = 1'b0;
        end
      end
    end
  end

  assign w_countZero  = (r_count == '0);
  assign w_decZero    = (w_decCount == '0);
  assign w_loadAccept = load && (r_state != S_RUN);

  // Next-state and next-count selection; same-cycle priority is load > pause > start.
  always_comb begin
    w_nextState  = r_state;
    w_nextCount  = r_count;
    w_tickAccept = 1'b0;
    case (r_state)
      S_IDLE, S_PAUSED: begin
        if (load) begin
          w_nextCount = w_clampCount;
        end else if (!pause && start) begin
          w_nextState = w_countZero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pause) begin
          w_nextState = S_PAUSED;
        end else if (tick) begin
          w_tickAccept = 1'b1;
          if (w_countZero || w_decZero) begin
            w_nextCount = '0;
            w_nextState = S_DONE;
          end else begin
            w_nextCount = w_decCount;
          end
        end
      end
      S_DONE: begin
        if (load) begin
          w_nextCount = w_clampCount;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State and count registers; reset restores the start value immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= START_BCD;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  assign count_bcd     = r_count;
  assign running       = (r_state == S_RUN);
  assign game_finished = (r_state == S_DONE);
  assign warn          = running && (r_count <= WARN_BCD);

`ifdef COUNTDOWN_BLINK_EN
  logic r_blink;
  logic w_blinkToggle;

  // The phase flips on every accepted tick that lands inside the warning window.
  assign w_blinkToggle = w_tickAccept && (w_nextState == S_RUN) &&
                         (w_nextCount <= WARN_BCD);

  // Blink phase register; cleared on reset, on a new load and when finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink <= 1'b0;
    end else if (w_loadAccept || (w_nextState == S_DONE)) begin
      r_blink <= 1'b0;
    end else if (w_blinkToggle) begin
      r_blink <= ~r_blink;
    end
  end

  // Display: steady zeros when finished, blank during the off phase, else the count.
  always_comb begin
    hex = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_state == S_DONE) begin
        hex[7*i +: 7] = f_seg(4'd0);
      end else if (r_blink) begin
        hex[7*i +: 7] = 7'b1111111;
      end else begin
        hex[7*i +: 7] = f_seg(r_count[4*i +: 4]);
      end
    end
  end
`else
  // Display follows the registered count digit by digit.
  always_comb begin
    hex = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex[7*i +: 7] = f_seg(r_count[4*i +: 4]);
    end
  end
`endif

endmodule
